unidade_de_controle: RTL and testbench
======================================

# unidade_de_controle

- Multi-cycle control FSM; the writer/driver side of the 7-entry, 16-bit register bank.
- Accepts one instruction per `run` handshake and sequences the bus source, register read select and one-hot register write enables over 2–4 cycles.
- Drives the ALU operand/result latches and signals completion with `done`.
- Sits between the instruction source (`din`) and the datapath: register bank, A/G registers, ALU, bus mux.

## Interface
Parameters:
- `DATA_W`, 16: width of `din` and the instruction word.
- `NUM_REGS`, 7: number of architectural registers (r0..r6). Register index 7 does not exist.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  start request; sampled only in IDLE.
- `din`  in  16  instruction word in the accept cycle; immediate in the mvi execute cycle.
- `ir_in`  out  1  load the instruction register from `din`.
- `registers_in`  out  7  one-hot write enables for r0..r6; at most one bit high.
- `register_out`  out  3  register bank read select.
- `bus_sel`  out  2  bus source: 0 = register bank, 1 = `din`, 2 = G, 3 = zero.
- `a_in`  out  1  load the A register from the bus.
- `g_in`  out  1  load the G register from the ALU.
- `alu_op`  out  2  ALU operation: 0 = add, 1 = sub, 2 = and.
- `done`  out  1  one-cycle completion pulse.
- `erro`  out  1  one-cycle pulse, coincident with `done`, for an illegal instruction.

## Operation
- Instruction fields:
  - `IR[15:13]` opcode.
  - `IR[12:10]` X (destination / first operand).
  - `IR[9:7]` Y (source).
  - Remaining bits ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and (see Configuration). 101–111 are illegal.
- States: IDLE, T1, T2, T3. Registered state plus the IR; all outputs are decoded Moore-style from state and IR.
- IDLE:
  - `ir_in` = `run`.
  - Moves to T1 if `run` is high, otherwise stays in IDLE.
- T1:
  - mv: `bus_sel`=0, `register_out`=Y, `registers_in[X]`=1, `done`=1 → IDLE.
  - mvi: `bus_sel`=1, `registers_in[X]`=1, `done`=1 → IDLE.
  - add/sub/and: `register_out`=X, `bus_sel`=0, `a_in`=1 → T2.
  - Illegal instruction: `done`=1, `erro`=1, no enables asserted → IDLE.
- T2 (add/sub/and): `register_out`=Y, `bus_sel`=0, `g_in`=1, `alu_op` per opcode → T3.
- T3 (add/sub/and): `bus_sel`=2, `registers_in[X]`=1, `done`=1 → IDLE.
- Illegal instruction, decided in T1: illegal opcode, or X=7, or (mv/add/sub/and with Y=7). mvi ignores Y.
- X=Y is legal (e.g. add r2,r2 doubles r2).
- Outputs not named in a state are 0; `register_out` is 0 when unused.

## Timing
- Reset:
  - State forced to IDLE and the IR cleared on the edge.
  - While `reset` is high, every output is gated to 0 in the same cycle, so no register write occurs.
  - Reset mid-instruction aborts it: no `done`, no partial write.
- Reset output values: `ir_in`, `registers_in`, `register_out`, `bus_sel`, `a_in`, `g_in`, `alu_op`, `done`, `erro` are all 0.
- Latency (cycle 0 = `run` high in IDLE):
  - mv/mvi/illegal: `done` in cycle 1 (2 cycles total).
  - add/sub/and: `done` in cycle 3 (4 cycles total).
- The register write takes effect on the clock edge ending the `done` cycle.
- Back-to-back: `run` high in the cycle after `done` is accepted (IDLE re-entered). `run` in non-IDLE states is ignored.
- mvi: the immediate must be valid on `din` during T1; the source holds it for that cycle.

## Configuration
- `UC_OP_AND_EN`: defined → opcode 100 is a legal AND (T1–T3 sequence, `alu_op`=2).
- Undefined → opcode 100 is illegal (`erro` pulse) and `alu_op` never takes value 2.

## Structure
- Shared package `processador_pkg` holds:
  - Opcode constants.
  - State encoding (IDLE/T1/T2/T3).
  - `bus_sel` encodings (SEL_REG/SEL_DIN/SEL_G/SEL_ZERO).
  - `alu_op` encodings.
- One sub-module, `decodificador_registrador`:
  - 3-bit index plus enable → 7-bit one-hot, with a `valido` output low for index 7.
  - Used for `registers_in` and for the illegal-index check.

## Test plan
- Reset held 3 cycles with `run`=1 and `din`=16'h2400 → all outputs 0 throughout. After release, IDLE accepts the pending `run`.
- `run` with mv r1,r3 (`din`=16'h0580) → cycle 1: `register_out`=3, `bus_sel`=0, `registers_in`=7'b0000010, `done`=1.
- mvi r5 (`din`=16'h3400, then 16'hBEEF in cycle 1) → cycle 1: `bus_sel`=1, `registers_in`=7'b0100000, `done`=1.
- sub r2,r6 (`din`=16'h6B00):
  - cycle 1: `a_in`=1, `register_out`=2.
  - cycle 2: `g_in`=1, `alu_op`=1, `register_out`=6.
  - cycle 3: `bus_sel`=2, `registers_in`=7'b0000100, `done`=1.
- mv r7,r0 (`din`=16'h1C00) and opcode 111 → cycle 1: `done`=1, `erro`=1, `registers_in`=0. Opcode 100 behaves the same when `UC_OP_AND_EN` is undefined.
- add started, then `reset` asserted in T2 → no `registers_in` bit ever high, no `done`. Next `run` starts a fresh instruction from IDLE.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared encodings for the processor control path: opcodes, FSM states, bus sources, ALU ops.
// Macro UC_OP_AND_EN makes opcode 100 a legal AND; otherwise it decodes as illegal.
package processador_pkg;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_AND = 3'b100
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T1   = 2'd1,
      ST_T2   = 2'd2,
      ST_T3   = 2'd3
   } estado_t;

   typedef enum logic [1:0] {
      SEL_REG  = 2'd0,
      SEL_DIN  = 2'd1,
      SEL_G    = 2'd2,
      SEL_ZERO = 2'd3
   } bus_sel_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2
   } alu_op_t;

   function automatic logic opcode_legal(input logic [2:0] op);
`ifdef UC_OP_AND_EN
      return op <= OP_AND;
`else
      return op <= OP_SUB;
`endif
   endfunction

   function automatic alu_op_t alu_of(input logic [2:0] op);
      alu_op_t r;
      case (op)
         OP_SUB:  r = ALU_SUB;
`ifdef UC_OP_AND_EN
         OP_AND:  r = ALU_AND;
`endif
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decodificador_registrador.sv
// Register index to one-hot write enable; valido flags indices that name a real register.
module decodificador_registrador
   import processador_pkg::*;
#(
   parameter int NUM_REGS = 7
) (
   input  logic [2:0]          idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot,
   output logic                valido
);

   assign valido = 32'(idx) < NUM_REGS;
   assign onehot = (en && valido) ? (NUM_REGS'(1) << idx) : '0;

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle control FSM driving the register bank, A/G latches, ALU and bus mux.
// Optional feature macro: UC_OP_AND_EN (opcode 100 executes as AND).
//
// state   | meaning
// IDLE    | waiting for run; latches IR from din when run is high
// T1      | mv/mvi write, illegal reject, or load A with R[X]
// T2      | put R[Y] on bus, load G with ALU result
// T3      | write G back into R[X]
module unidade_de_controle
   import processador_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 7
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   input  logic [DATA_W-1:0]   din,
   output logic                ir_in,
   output logic [NUM_REGS-1:0] registers_in,
   output logic [2:0]          register_out,
   output logic [1:0]          bus_sel,
   output logic                a_in,
   output logic                g_in,
   output logic [1:0]          alu_op,
   output logic                done,
   output logic                erro
);

   estado_t    state_q, state_d;
   logic [8:0] ir_q, ir_d;
   logic [2:0] opcode, x, y;
   logic       x_valido, legal, wr_en;
   logic       ir_in_c, a_c, g_c, done_c, erro_c;
   logic [2:0] rout_c;
   bus_sel_t   bsel_c;
   alu_op_t    alu_c;
   logic       unused_din_bits;

   // Only opcode/X/Y are kept; the low instruction bits carry no meaning.
   assign unused_din_bits = ^din[DATA_W-10:0];

   assign opcode = ir_q[8:6];
   assign x      = ir_q[5:3];
   assign y      = ir_q[2:0];
   assign legal  = opcode_legal(opcode) && x_valido && (opcode == OP_MVI || y != 3'd7);

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      wr_en   = 1'b0;
      ir_in_c = 1'b0;
      rout_c  = '0;
      bsel_c  = SEL_REG;
      a_c     = 1'b0;
      g_c     = 1'b0;
      alu_c   = ALU_ADD;
      done_c  = 1'b0;
      erro_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ir_in_c = run;
            if (run) begin
               ir_d    = din[DATA_W-1 -: 9];
               state_d = ST_T1;
            end
         end
         ST_T1: begin
            if (!legal) begin
               done_c  = 1'b1;
               erro_c  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               case (opcode)
                  OP_MV: begin
                     rout_c  = y;
                     wr_en   = 1'b1;
                     done_c  = 1'b1;
                     state_d = ST_IDLE;
                  end
                  OP_MVI: begin
                     bsel_c  = SEL_DIN;
                     wr_en   = 1'b1;
                     done_c  = 1'b1;
                     state_d = ST_IDLE;
                  end
                  default: begin
                     rout_c  = x;
                     a_c     = 1'b1;
                     state_d = ST_T2;
                  end
               endcase
            end
         end
         ST_T2: begin
            rout_c  = y;
            g_c     = 1'b1;
            alu_c   = alu_of(opcode);
            state_d = ST_T3;
         end
         ST_T3: begin
            bsel_c  = SEL_G;
            wr_en   = 1'b1;
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   decodificador_registrador #(.NUM_REGS(NUM_REGS)) u_dec_x (
      .idx    (x),
      .en     (wr_en & ~reset),
      .onehot (registers_in),
      .valido (x_valido)
   );

   // Reset gates every strobe in the same cycle so an aborted instruction writes nothing.
   assign ir_in        = ir_in_c & ~reset;
   assign register_out = reset ? 3'd0 : rout_c;
   assign bus_sel      = reset ? 2'd0 : bsel_c;
   assign a_in         = a_c & ~reset;
   assign g_in         = g_c & ~reset;
   assign alu_op       = reset ? 2'd0 : alu_c;
   assign done         = done_c & ~reset;
   assign erro         = erro_c & ~reset;

endmodule

// File: tb/tb_unidade_de_controle.sv
// Self-checking bench for unidade_de_controle: directed vector table plus randomized instructions.
module tb_unidade_de_controle;

   typedef struct packed {
      logic       ir_in;
      logic [6:0] registers_in;
      logic [2:0] register_out;
      logic [1:0] bus_sel;
      logic       a_in;
      logic       g_in;
      logic [1:0] alu_op;
      logic       done;
      logic       erro;
   } outs_t;

   typedef struct {
      logic        rst;
      logic        run;
      logic [15:0] din;
      outs_t       exp;
      string       name;
   } vec_t;

   logic        clock, reset, run;
   logic [15:0] din;
   logic        ir_in, a_in, g_in, done, erro;
   logic [6:0]  registers_in;
   logic [2:0]  register_out;
   logic [1:0]  bus_sel, alu_op;

   int    n_vec = 0;
   int    n_err = 0;
   vec_t  tbl[$];
   outs_t exp_q[$];
   outs_t zero = '0;

`ifdef UC_OP_AND_EN
   localparam bit AND_EN = 1'b1;
`else
   localparam bit AND_EN = 1'b0;
`endif

   unidade_de_controle dut (
      .clock(clock), .reset(reset), .run(run), .din(din),
      .ir_in(ir_in), .registers_in(registers_in), .register_out(register_out),
      .bus_sel(bus_sel), .a_in(a_in), .g_in(g_in), .alu_op(alu_op),
      .done(done), .erro(erro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic outs_t o(input logic ii, input logic [6:0] ri, input logic [2:0] ro,
                               input logic [1:0] bs, input logic a, input logic g,
                               input logic [1:0] al, input logic d, input logic e);
      outs_t r;
      r = '{ir_in: ii, registers_in: ri, register_out: ro, bus_sel: bs,
            a_in: a, g_in: g, alu_op: al, done: d, erro: e};
      return r;
   endfunction

   function automatic void add(input logic r, input logic rn, input logic [15:0] d,
                               input outs_t e, input string nm);
      vec_t v;
      v.rst = r; v.run = rn; v.din = d; v.exp = e; v.name = nm;
      tbl.push_back(v);
   endfunction

   // Expected per-cycle outputs of one instruction, cycle 0 being the accept cycle.
   function automatic void build(input logic [15:0] w);
      int op, x, y;
      bit ok;
      op = int'(w[15:13]);
      x  = int'(w[12:10]);
      y  = int'(w[9:7]);
      ok = (op <= 3 || (op == 4 && AND_EN)) && x < 7 && (op == 1 || y < 7);
      exp_q.delete();
      exp_q.push_back(o(1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!ok) begin
         exp_q.push_back(o(0, 0, 0, 0, 0, 0, 0, 1, 1));
      end else if (op == 0) begin
         exp_q.push_back(o(0, 7'(1 << x), 3'(y), 0, 0, 0, 0, 1, 0));
      end else if (op == 1) begin
         exp_q.push_back(o(0, 7'(1 << x), 0, 1, 0, 0, 0, 1, 0));
      end else begin
         exp_q.push_back(o(0, 0, 3'(x), 0, 1, 0, 0, 0, 0));
         exp_q.push_back(o(0, 0, 3'(y), 0, 0, 1, 2'(op - 2), 0, 0));
         exp_q.push_back(o(0, 7'(1 << x), 0, 2, 0, 0, 0, 1, 0));
      end
   endfunction

   task automatic apply(input logic r, input logic rn, input logic [15:0] d,
                        input outs_t e, input string nm);
      outs_t got;
      @(posedge clock);
      #1;
      reset = r; run = rn; din = d;
      @(negedge clock);
      got = '{ir_in: ir_in, registers_in: registers_in, register_out: register_out,
              bus_sel: bus_sel, a_in: a_in, g_in: g_in, alu_op: alu_op,
              done: done, erro: erro};
      n_vec++;
      if (got !== e) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (ir_in|regs_in|reg_out|bus|a|g|alu|done|erro)",
                  nm, got, e);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; din = '0;

      for (int i = 0; i < 3; i++) add(1, 1, 16'h2400, zero, "reset_hold");
      add(0, 1, 16'h2400, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_accept");
      add(0, 0, 16'hBEEF, o(0, 7'b0000010, 0, 1, 0, 0, 0, 1, 0), "post_reset_mvi_r1");
      add(0, 0, 16'h0000, zero, "idle");
      add(0, 1, 16'h0580, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "mv_accept");
      add(0, 0, 16'h0000, o(0, 7'b0000010, 3, 0, 0, 0, 0, 1, 0), "mv_r1_r3");
      add(0, 1, 16'h3400, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "mvi_accept");
      add(0, 1, 16'hBEEF, o(0, 7'b0100000, 0, 1, 0, 0, 0, 1, 0), "mvi_r5_run_ignored");
      add(0, 0, 16'h0000, zero, "idle_after_mvi");
      add(0, 1, 16'h6B00, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "sub_accept");
      add(0, 1, 16'h0000, o(0, 0, 2, 0, 1, 0, 0, 0, 0), "sub_t1");
      add(0, 1, 16'h0000, o(0, 0, 6, 0, 0, 1, 1, 0, 0), "sub_t2");
      add(0, 0, 16'h0000, o(0, 7'b0000100, 0, 2, 0, 0, 0, 1, 0), "sub_t3");
      add(0, 1, 16'h1C00, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "mv_r7_accept");
      add(0, 0, 16'h0000, o(0, 0, 0, 0, 0, 0, 0, 1, 1), "mv_r7_illegal");
      add(0, 1, 16'hE000, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "op111_accept");
      add(0, 0, 16'h0000, o(0, 0, 0, 0, 0, 0, 0, 1, 1), "op111_illegal");
      add(0, 1, 16'h0380, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "mv_y7_accept");
      add(0, 0, 16'h0000, o(0, 0, 0, 0, 0, 0, 0, 1, 1), "mv_y7_illegal");
      add(0, 1, 16'h2380, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "mvi_y7_accept");
      add(0, 0, 16'h1234, o(0, 7'b0000001, 0, 1, 0, 0, 0, 1, 0), "mvi_y7_legal");
      add(0, 1, 16'h8900, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "op100_accept");
`ifdef UC_OP_AND_EN
      add(0, 0, 16'h0000, o(0, 0, 2, 0, 1, 0, 0, 0, 0), "and_t1");
      add(0, 0, 16'h0000, o(0, 0, 2, 0, 0, 1, 2, 0, 0), "and_t2");
      add(0, 0, 16'h0000, o(0, 7'b0000100, 0, 2, 0, 0, 0, 1, 0), "and_t3");
`else
      add(0, 0, 16'h0000, o(0, 0, 0, 0, 0, 0, 0, 1, 1), "op100_illegal");
`endif
      add(0, 1, 16'h4500, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "add_accept");
      add(0, 0, 16'h0000, o(0, 0, 1, 0, 1, 0, 0, 0, 0), "add_t1");
      add(1, 0, 16'h0000, zero, "add_reset_in_t2");
      add(0, 0, 16'h0000, zero, "after_abort_idle");
      add(0, 0, 16'h0000, zero, "after_abort_idle2");
      add(0, 1, 16'h0080, o(1, 0, 0, 0, 0, 0, 0, 0, 0), "fresh_accept");
      add(0, 0, 16'h0000, o(0, 7'b0000001, 1, 0, 0, 0, 0, 1, 0), "fresh_mv_r0_r1");

      foreach (tbl[i]) apply(tbl[i].rst, tbl[i].run, tbl[i].din, tbl[i].exp, tbl[i].name);

      for (int i = 0; i < 400; i++) begin
         logic [15:0] w;
         int abort_at;
         if ($urandom_range(0, 3) == 0) apply(0, 0, 16'($urandom), zero, "rand_idle");
         w = 16'($urandom);
         build(w);
         abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, exp_q.size() - 1)) : -1;
         for (int c = 0; c < exp_q.size(); c++) begin
            if (c == abort_at) begin
               apply(1, 1'($urandom), 16'($urandom), zero, "rand_reset_abort");
               break;
            end
            if (c == 0) apply(0, 1, w, exp_q[c], "rand_accept");
            else        apply(0, 1'($urandom), 16'($urandom), exp_q[c], "rand_exec");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
